// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and default widths for the memory-port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, IF_BUSY = 2'b01, D_BUSY = 2'b10} state_t;
    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 64;
    localparam int AGE_W = 4;
endpackage

// File: rtl/mem_arb_age.sv
// mem_arb_age: counts data grants made while fetch waits and raises force_if at AGE_MAX
// (only instantiated when MEM_ARB_AGING_EN is defined)
module mem_arb_age
    import mem_arb_pkg::*;
#(
    parameter int AGE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic gnt_if,
    input  logic gnt_d,
    output logic force_if
);
    logic [AGE_W-1:0] age;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            age <= '0;
        else if (!if_req || gnt_if)
            age <= '0;
        else if (gnt_d && age != '1)
            age <= age + 1'b1;
    end
    assign force_if = age == AGE_W'(AGE_MAX);
endmodule

// File: rtl/mem_port_arbi.sv
// mem_port_arbi: arbitrates fetch and data requesters onto one memory port, data first.
// Define MEM_ARB_AGING_EN to add the fetch anti-starvation aging counter.
module mem_port_arbi
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int AGE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_grnt,
    output logic              d_grnt,
    output logic              if_done,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);
    state_t state;
    logic arb, force_if, gnt_if, gnt_d;
    // the requester finishing this cycle sits out the arbitration it triggers
    assign arb    = state == IDLE || mem_done;
    assign gnt_d  = arb && state != D_BUSY && d_req && !(force_if && state != IF_BUSY && if_req);
    assign gnt_if = arb && state != IF_BUSY && if_req && !gnt_d;
`ifdef MEM_ARB_AGING_EN
    mem_arb_age #(.AGE_MAX(AGE_MAX)) u_age (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .gnt_if   (gnt_if),
        .gnt_d    (gnt_d),
        .force_if (force_if)
    );
`else
    assign force_if = AGE_MAX < 0;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            if_grnt   <= 1'b0;
            d_grnt    <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (gnt_d) begin
            state     <= D_BUSY;
            if_grnt   <= 1'b0;
            d_grnt    <= 1'b1;
            mem_en    <= 1'b1;
            mem_wr    <= d_wr;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
        end else if (gnt_if) begin
            state     <= IF_BUSY;
            if_grnt   <= 1'b1;
            d_grnt    <= 1'b0;
            mem_en    <= 1'b1;
            mem_wr    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
        end else if (arb) begin
            state     <= IDLE;
            if_grnt   <= 1'b0;
            d_grnt    <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end
    end
    assign if_done = mem_done && state == IF_BUSY;
    assign d_done  = mem_done && state == D_BUSY;
    assign rdata   = (if_done || (d_done && !mem_wr)) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbi.sv
// tb_mem_port_arbi: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_port_arbi;
    localparam int AW = 16, DW = 64, AMAX = 4;
    logic clk = 0, rst = 0;
    logic if_req = 0, d_req = 0, d_wr = 0, mem_done = 0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic if_grnt, d_grnt, if_done, d_done, mem_en, mem_wr;
    logic [DW-1:0] rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    int checks = 0, errors = 0;
    bit run = 0;

    mem_port_arbi #(.ADDR_W(AW), .DATA_W(DW), .AGE_MAX(AMAX)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_req(d_req), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .if_grnt(if_grnt), .d_grnt(d_grnt), .if_done(if_done), .d_done(d_done), .rdata(rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // model: who owns the port (0 none, 1 fetch, 2 data) and what was captured at grant
    int own = 0, age = 0;
    logic m_wr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    always @(posedge clk or negedge rst) begin
        bit can_arb, want_if, want_d, frc;
        if (!rst) begin
            own = 0; age = 0; m_wr = 0; m_addr = '0; m_wd = '0;
        end else begin
            can_arb = own == 0 || mem_done;
            want_if = can_arb && own != 1 && if_req;
            want_d  = can_arb && own != 2 && d_req;
`ifdef MEM_ARB_AGING_EN
            frc = age == AMAX;
`else
            frc = 0;
`endif
            if (want_d && !(frc && want_if)) begin
                age = (if_req && age < 15) ? age + 1 : (if_req ? age : 0);
                own = 2; m_wr = d_wr; m_addr = d_addr; m_wd = d_wdata;
            end else if (want_if) begin
                age = 0;
                own = 1; m_wr = 0; m_addr = if_addr; m_wd = '0;
            end else begin
                if (!if_req) age = 0;
                if (can_arb) begin own = 0; m_wr = 0; m_addr = '0; m_wd = '0; end
            end
        end
    end

    always @(negedge clk) begin
        if (run && rst === 1'b1) begin
            chk("if_grnt", if_grnt, own == 1);
            chk("d_grnt", d_grnt, own == 2);
            chk("mem_en", mem_en, own != 0);
            chk("mem_wr", mem_wr, m_wr);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wd);
            chk("if_done", if_done, mem_done && own == 1);
            chk("d_done", d_done, mem_done && own == 2);
            chk("rdata", rdata, (mem_done && (own == 1 || (own == 2 && !m_wr))) ? mem_rdata : 64'h0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string n);
        chk({n, "_en"}, mem_en, 0);
        chk({n, "_grnt"}, {if_grnt, d_grnt}, 0);
        chk({n, "_addr"}, mem_addr, 0);
        chk({n, "_wr"}, mem_wr, 0);
        chk({n, "_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        bit ifd, dd;
        @(negedge clk);
        chk_idle("reset");
        cyc(); rst = 1; run = 1;
        // data write, done three cycles after grant
        d_req = 1; d_wr = 1; d_addr = 16'h0040; d_wdata = 64'hA5;
        cyc(); @(negedge clk);
        chk("t1_dgrnt", d_grnt, 1); chk("t1_en", mem_en, 1); chk("t1_wr", mem_wr, 1);
        chk("t1_addr", mem_addr, 16'h0040); chk("t1_wdata", mem_wdata, 64'hA5);
        cyc(); cyc(); cyc(); mem_done = 1;
        @(negedge clk);
        chk("t1_done", d_done, 1); chk("t1_rdata", rdata, 0);
        cyc(); mem_done = 0; d_req = 0; d_wr = 0;
        @(negedge clk);
        chk_idle("t1_idle");
        // both request: data first, then fetch back-to-back
        if_req = 1; if_addr = 16'h0100; d_req = 1; d_addr = 16'h0200;
        cyc(); @(negedge clk);
        chk("t2_dgrnt", d_grnt, 1); chk("t2_ifgrnt", if_grnt, 0);
        cyc(); mem_done = 1; mem_rdata = 64'h55;
        @(negedge clk);
        chk("t2_ddone", d_done, 1); chk("t2_drdata", rdata, 64'h55);
        cyc(); mem_done = 0; d_req = 0;
        @(negedge clk);
        chk("t2_ifgrnt2", if_grnt, 1); chk("t2_en", mem_en, 1);
        chk("t2_addr", mem_addr, 16'h0100); chk("t2_wr", mem_wr, 0);
        cyc(); mem_done = 1; mem_rdata = 64'h1234;
        @(negedge clk);
        chk("t3_ifdone", if_done, 1); chk("t3_rdata", rdata, 64'h1234);
        cyc(); mem_done = 0; if_req = 0;
        @(negedge clk);
        chk("t3_rdata0", rdata, 0);
        chk_idle("t3_idle");
        // async reset in the middle of a data operation
        d_req = 1; d_addr = 16'h0777; d_wr = 1; d_wdata = 64'hFF;
        cyc(); @(negedge clk);
        chk("t4_dgrnt", d_grnt, 1);
        #2 rst = 0; #1;
        chk_idle("t4_rst");
        d_req = 0; d_wr = 0;
        cyc(); rst = 1; mem_done = 1;
        @(negedge clk);
        chk("t4_stray", {if_done, d_done}, 0);
        cyc(); mem_done = 0;
        @(negedge clk);
        chk_idle("t4_after");
        // fetch holds its request through done: one idle cycle, then regranted
        if_req = 1; if_addr = 16'h0300;
        cyc(); @(negedge clk);
        chk("t5_grnt", if_grnt, 1);
        cyc(); mem_done = 1;
        @(negedge clk);
        chk("t5_done", if_done, 1);
        cyc(); mem_done = 0;
        @(negedge clk);
        chk("t5_bubble", mem_en, 0);
        cyc(); @(negedge clk);
        chk("t5_regrant", if_grnt, 1); chk("t5_addr", mem_addr, 16'h0300);
        cyc(); mem_done = 1;
        cyc(); mem_done = 0; if_req = 0;
        // randomized traffic checked every cycle by the compare process
        ifd = 0; dd = 0;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if (i == 2000) rst = 0;
            if (i == 2003) rst = 1;
            if (ifd) if_req = $urandom_range(0, 3) == 0;
            if (dd) d_req = $urandom_range(0, 3) == 0;
            if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = AW'($urandom); end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_wr = $urandom_range(0, 1) == 1; d_addr = AW'($urandom); d_wdata = {$urandom, $urandom};
            end
            mem_done = mem_en ? $urandom_range(0, 2) == 0 : $urandom_range(0, 29) == 0;
            mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            ifd = if_done; dd = d_done;
        end
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbi.md
# mem_port_arbi

Two-requester arbiter and sequencer for the single memory port shared by the instruction-fetch miss path and the data path (the output of the load/store arbiter). It grants one requester at a time and latches that requester's address, write flag and write data. It drives the memory enable/address/write controls until the memory reports completion. Data requests have priority over fetch. An optional aging counter prevents fetch starvation.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 64, memory data width (one cache line beat)
- AGE_MAX, 4, consecutive data grants tolerated while fetch waits (aging build only; legal range 1..15)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, level; held until if_done
- if_addr  in  ADDR_W  fetch address, sampled at grant
- d_req  in  1  data request, level; held until d_done
- d_wr  in  1  1 = write, 0 = read; sampled at grant
- d_addr  in  ADDR_W  data address, sampled at grant
- d_wdata  in  DATA_W  write data, sampled at grant
- mem_done  in  1  memory operation complete, one-cycle pulse
- mem_rdata  in  DATA_W  read data, valid with mem_done
- if_grnt  out  1  fetch owns the port
- d_grnt  out  1  data owns the port
- if_done  out  1  fetch operation complete
- d_done  out  1  data operation complete
- rdata  out  DATA_W  read data to the owner
- mem_en  out  1  memory operation enable
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data

## Operation
- States: IDLE, IF_BUSY, D_BUSY.
- Arbitration runs in IDLE and on any cycle where mem_done=1 in a BUSY state.
  - Priority is d_req over if_req.
  - The requester whose operation completes this cycle is excluded from that cycle's arbitration.
  - No eligible requester leads to IDLE.
- On a grant, the request fields are registered into the mem_* holding registers. Fetch always has mem_wr=0 and mem_wdata=0.
- In IF_BUSY, if_grnt=1 and mem_en=1. In D_BUSY, d_grnt=1 and mem_en=1. Both persist until the cycle mem_done is sampled.
- if_done = mem_done & IF_BUSY. d_done = mem_done & D_BUSY. Both are combinational. rdata = mem_rdata on a read done, otherwise 0.
- mem_done in IDLE is ignored.
- Reset, asynchronous, including mid-operation:
  - State returns to IDLE.
  - All outputs and holding registers go to 0.
  - The aging counter goes to 0.
  - Any in-flight memory operation is abandoned; the memory shares rst.

## Timing
- In IDLE, a request sampled at edge t gives a grant, mem_en and valid mem_addr/mem_wr/mem_wdata from t+1. Latency is 1 cycle.
- Done is in the same cycle as mem_done. The requester drops req by the next edge.
- Back-to-back operation: if the other requester is pending at mem_done, the next grant starts on the following cycle with no IDLE bubble.
- mem_en is low for at most zero cycles between back-to-back operations of different requesters.
- A requester re-requesting immediately after its own done is arbitrated from IDLE one cycle later.

## Configuration
- MEM_ARB_AGING_EN defined:
  - A 4-bit age counter increments on each data grant made while if_req=1.
  - It clears on a fetch grant or whenever if_req=0.
  - When age == AGE_MAX, fetch wins the next arbitration even if d_req=1.
- MEM_ARB_AGING_EN undefined: strict data priority, no counter logic. Fetch can starve.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE=2'b00, IF_BUSY=2'b01, D_BUSY=2'b10);
  - the default ADDR_W/DATA_W constants;
  - the age counter width.
- One natural sub-module, mem_arb_age. It contains the aging counter plus the fetch-force flag and is instantiated only under MEM_ARB_AGING_EN.

## Test plan
- Reset then d_req=1, d_wr=1, d_addr=16'h0040, d_wdata=64'hA5 → at t+1: d_grnt=1, mem_en=1, mem_wr=1, mem_addr=0040. mem_done 3 cycles later → d_done pulse, then IDLE with all outputs 0.
- if_req and d_req both asserted in IDLE → D_BUSY first. At its mem_done, IF_BUSY starts the next cycle with mem_addr=if_addr and mem_wr=0.
- Fetch read with mem_rdata=64'h1234 on mem_done → if_done=1 and rdata=64'h1234 in the same cycle. rdata=0 otherwise.
- Aging build, AGE_MAX=2, d_req held high with repeated requests, if_req high:
  - two data grants, then a fetch grant;
  - the counter then clears.
  - Non-aging build: data grants only.
- rst low during D_BUSY → outputs 0 immediately. After release with no requests, the block stays in IDLE and a stray mem_done is ignored.
- A requester holds req through its done cycle, with the other idle → IDLE for one cycle, then a fresh grant to the same requester.
